// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, ALU operand selects, sequencer states.
package cpu_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'h0;
  localparam logic [3:0] OP_MOV_AB = 4'h1;
  localparam logic [3:0] OP_IN_A   = 4'h2;
  localparam logic [3:0] OP_MOV_AI = 4'h3;
  localparam logic [3:0] OP_MOV_BA = 4'h4;
  localparam logic [3:0] OP_ADD_B  = 4'h5;
  localparam logic [3:0] OP_IN_B   = 4'h6;
  localparam logic [3:0] OP_MOV_BI = 4'h7;
  localparam logic [3:0] OP_OUT_B  = 4'h9;
  localparam logic [3:0] OP_OUT_I  = 4'hB;
  localparam logic [3:0] OP_JNC    = 4'hE;
  localparam logic [3:0] OP_JMP    = 4'hF;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder: opcode plus current carry flag to datapath controls.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic       c_flag,
  output logic [1:0] sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       illegal,
  output logic       is_add
);

  always_comb begin
    sel     = SEL_A;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_out  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    illegal = 1'b0;
    is_add  = 1'b0;
    case (op)
      OP_ADD_A:  begin sel = SEL_A;    ld_a   = 1'b1; pc_inc = 1'b1; is_add = 1'b1; end
      OP_MOV_AB: begin sel = SEL_B;    ld_a   = 1'b1; pc_inc = 1'b1; end
      OP_IN_A:   begin sel = SEL_IN;   ld_a   = 1'b1; pc_inc = 1'b1; end
      OP_MOV_AI: begin sel = SEL_ZERO; ld_a   = 1'b1; pc_inc = 1'b1; end
      OP_MOV_BA: begin sel = SEL_A;    ld_b   = 1'b1; pc_inc = 1'b1; end
      OP_ADD_B:  begin sel = SEL_B;    ld_b   = 1'b1; pc_inc = 1'b1; is_add = 1'b1; end
      OP_IN_B:   begin sel = SEL_IN;   ld_b   = 1'b1; pc_inc = 1'b1; end
      OP_MOV_BI: begin sel = SEL_ZERO; ld_b   = 1'b1; pc_inc = 1'b1; end
      OP_OUT_B:  begin sel = SEL_B;    ld_out = 1'b1; pc_inc = 1'b1; end
      OP_OUT_I:  begin sel = SEL_ZERO; ld_out = 1'b1; pc_inc = 1'b1; end
      // Jump taken only when the carry from the previous instruction is clear
      OP_JNC: begin
        sel     = SEL_ZERO;
        pc_load = ~c_flag;
        pc_inc  = c_flag;
      end
      OP_JMP:    begin sel = SEL_ZERO; pc_load = 1'b1; end
      default:   begin pc_inc = 1'b1; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller: ROM handshake, instruction register, carry flag, EXEC-gated controls.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned IW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          rom_req,
  input  logic          rom_ack,
  input  logic [IW-1:0] rom_data,
  input  logic          alu_carry,
  output logic          pc_inc,
  output logic          pc_load,
  output logic [AW-1:0] pc_data,
  output logic [1:0]    sel,
  output logic [3:0]    imm,
  output logic          ld_a,
  output logic          ld_b,
  output logic          ld_out,
  output logic          c_flag,
  output logic          busy,
  output logic          illegal
);

  state_t        state, state_d;
  logic [IW-1:0] ir;
  logic          exec;

  logic [1:0] d_sel;
  logic       d_ld_a, d_ld_b, d_ld_out, d_pc_inc, d_pc_load, d_illegal, d_is_add;

  cpu_decode u_decode (
    .op      (ir[IW-1:IW-4]),
    .c_flag  (c_flag),
    .sel     (d_sel),
    .ld_a    (d_ld_a),
    .ld_b    (d_ld_b),
    .ld_out  (d_ld_out),
    .pc_inc  (d_pc_inc),
    .pc_load (d_pc_load),
    .illegal (d_illegal),
    .is_add  (d_is_add)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ir     <= '0;
      c_flag <= 1'b0;
    end else begin
      state <= state_d;
      if (state == FETCH && rom_ack)
        ir <= rom_data;
      if (state == EXEC)
        c_flag <= d_is_add ? alu_carry : 1'b0;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (run) state_d = FETCH;
      FETCH:   if (rom_ack) state_d = EXEC;
      EXEC:    state_d = run ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controls come straight from the registered state, so an async reset silences them at once
  assign exec    = (state == EXEC);
  assign rom_req = (state == FETCH);
  assign busy    = (state != IDLE);
  assign sel     = exec ? d_sel : SEL_A;
  assign ld_a    = exec & d_ld_a;
  assign ld_b    = exec & d_ld_b;
  assign ld_out  = exec & d_ld_out;
  assign pc_inc  = exec & d_pc_inc;
  assign pc_load = exec & d_pc_load;
  assign illegal = exec & d_illegal;
  assign imm     = ir[3:0];
  assign pc_data = ir[AW-1:0];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: opcode table plus handshake/run/reset sequences.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, rom_ack, alu_carry;
  logic [7:0] rom_data;
  logic       rom_req, pc_inc, pc_load, ld_a, ld_b, ld_out, c_flag, busy, illegal;
  logic [3:0] pc_data, imm;
  logic [1:0] sel;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.IW(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .run(run), .rom_req(rom_req), .rom_ack(rom_ack),
    .rom_data(rom_data), .alu_carry(alu_carry), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_data(pc_data), .sel(sel), .imm(imm), .ld_a(ld_a), .ld_b(ld_b),
    .ld_out(ld_out), .c_flag(c_flag), .busy(busy), .illegal(illegal)
  );

  typedef struct {
    logic [7:0] instr;
    logic       carry;
    logic [1:0] sel;
    logic       sel_care;
    logic       la, lb, lo, inc, load, ill, c_after;
  } vec_t;

  vec_t v[18];

  function automatic vec_t mk(input logic [7:0] instr, input logic carry,
                              input logic [1:0] s, input logic care,
                              input logic la, input logic lb, input logic lo,
                              input logic inc, input logic load, input logic ill,
                              input logic c_after);
    vec_t r;
    r.instr = instr; r.carry = carry; r.sel = s; r.sel_care = care;
    r.la = la; r.lb = lb; r.lo = lo; r.inc = inc; r.load = load;
    r.ill = ill; r.c_after = c_after;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_no_pulse(input string tag);
    chk({tag, " ld_a"}, 32'(ld_a), 0);
    chk({tag, " ld_b"}, 32'(ld_b), 0);
    chk({tag, " ld_out"}, 32'(ld_out), 0);
    chk({tag, " pc_inc"}, 32'(pc_inc), 0);
    chk({tag, " pc_load"}, 32'(pc_load), 0);
    chk({tag, " illegal"}, 32'(illegal), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_no_pulse(tag);
    chk({tag, " rom_req"}, 32'(rom_req), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " sel"}, 32'(sel), 0);
    chk({tag, " imm"}, 32'(imm), 0);
    chk({tag, " pc_data"}, 32'(pc_data), 0);
    chk({tag, " c_flag"}, 32'(c_flag), 0);
  endtask

  initial begin
    int req_cycles;
    //          instr  cy  sel   care la lb lo inc ld ill c
    v[0]  = mk(8'h33, 0, 2'd3, 1, 1, 0, 0, 1, 0, 0, 0);
    v[1]  = mk(8'h01, 1, 2'd0, 1, 1, 0, 0, 1, 0, 0, 1);
    v[2]  = mk(8'hE5, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
    v[3]  = mk(8'hE5, 1, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0);
    v[4]  = mk(8'h1A, 1, 2'd1, 1, 1, 0, 0, 1, 0, 0, 0);
    v[5]  = mk(8'h20, 0, 2'd2, 1, 1, 0, 0, 1, 0, 0, 0);
    v[6]  = mk(8'h42, 0, 2'd0, 1, 0, 1, 0, 1, 0, 0, 0);
    v[7]  = mk(8'h57, 1, 2'd1, 1, 0, 1, 0, 1, 0, 0, 1);
    v[8]  = mk(8'h6C, 1, 2'd2, 1, 0, 1, 0, 1, 0, 0, 0);
    v[9]  = mk(8'h7E, 0, 2'd3, 1, 0, 1, 0, 1, 0, 0, 0);
    v[10] = mk(8'h9D, 0, 2'd1, 1, 0, 0, 1, 1, 0, 0, 0);
    v[11] = mk(8'hB4, 0, 2'd3, 1, 0, 0, 1, 1, 0, 0, 0);
    v[12] = mk(8'h0F, 1, 2'd0, 1, 1, 0, 0, 1, 0, 0, 1);
    v[13] = mk(8'h8A, 1, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0);
    v[14] = mk(8'hF9, 0, 2'd3, 1, 0, 0, 0, 0, 1, 0, 0);
    v[15] = mk(8'hA0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0);
    v[16] = mk(8'hC3, 1, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0);
    v[17] = mk(8'hD1, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0);

    rst = 1'b1; run = 1'b0; rom_ack = 1'b0; rom_data = 8'h00; alu_carry = 1'b0;
    #2;
    chk_all_zero("reset");
    step();
    rst = 1'b0;
    run = 1'b1;
    step();

    // Zero-wait table: FETCH with immediate ack, then EXEC, then back to FETCH.
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("v%0d fetch rom_req", i), 32'(rom_req), 1);
      rom_ack = 1'b1; rom_data = v[i].instr; alu_carry = v[i].carry;
      step();
      rom_ack = 1'b0; rom_data = 8'h00;
      if (v[i].sel_care) chk($sformatf("v%0d sel", i), 32'(sel), 32'(v[i].sel));
      chk($sformatf("v%0d ld_a", i), 32'(ld_a), 32'(v[i].la));
      chk($sformatf("v%0d ld_b", i), 32'(ld_b), 32'(v[i].lb));
      chk($sformatf("v%0d ld_out", i), 32'(ld_out), 32'(v[i].lo));
      chk($sformatf("v%0d pc_inc", i), 32'(pc_inc), 32'(v[i].inc));
      chk($sformatf("v%0d pc_load", i), 32'(pc_load), 32'(v[i].load));
      chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(v[i].ill));
      chk($sformatf("v%0d imm", i), 32'(imm), 32'(v[i].instr[3:0]));
      chk($sformatf("v%0d pc_data", i), 32'(pc_data), 32'(v[i].instr[3:0]));
      chk($sformatf("v%0d exec rom_req", i), 32'(rom_req), 0);
      chk($sformatf("v%0d busy", i), 32'(busy), 1);
      step();
      alu_carry = 1'b0;
      chk($sformatf("v%0d c_flag", i), 32'(c_flag), 32'(v[i].c_after));
      chk_no_pulse($sformatf("v%0d after", i));
    end

    // Wait states: ack on the 4th FETCH cycle, a single EXEC follows.
    req_cycles = 0;
    for (int w = 0; w < 3; w++) begin
      if (rom_req) req_cycles++;
      chk_no_pulse($sformatf("wait%0d", w));
      rom_data = 8'hFF;
      step();
    end
    if (rom_req) req_cycles++;
    rom_ack = 1'b1; rom_data = 8'h35;
    step();
    rom_ack = 1'b0; rom_data = 8'h00;
    chk("wait req_cycles", 32'(req_cycles), 4);
    chk("wait exec ld_a", 32'(ld_a), 1);
    chk("wait exec imm", 32'(imm), 5);
    chk("wait exec sel", 32'(sel), 3);
    step();
    chk_no_pulse("wait after");
    chk("wait back fetch", 32'(rom_req), 1);

    // run dropped mid-FETCH: instruction completes, then IDLE until run returns.
    run = 1'b0;
    step();
    chk("rundrop still fetch", 32'(rom_req), 1);
    rom_ack = 1'b1; rom_data = 8'h7C;
    step();
    rom_ack = 1'b0;
    chk("rundrop exec ld_b", 32'(ld_b), 1);
    chk("rundrop exec pc_inc", 32'(pc_inc), 1);
    step();
    chk("rundrop idle busy", 32'(busy), 0);
    chk("rundrop idle rom_req", 32'(rom_req), 0);
    chk_no_pulse("rundrop idle");
    step();
    chk("rundrop stay idle", 32'(busy), 0);
    run = 1'b1;
    step();
    chk("resume fetch rom_req", 32'(rom_req), 1);
    chk("resume busy", 32'(busy), 1);

    // Async reset mid-FETCH with an ack pending: drops at once, ack discarded.
    rom_ack = 1'b1; rom_data = 8'h3A;
    #2;
    rst = 1'b1;
    #1;
    chk("rstfetch rom_req", 32'(rom_req), 0);
    chk("rstfetch busy", 32'(busy), 0);
    run = 1'b0;
    step();
    rom_ack = 1'b0;
    rst = 1'b0;
    step();
    step();
    chk_all_zero("post reset idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/execute controller for the 4-bit CPU. It fetches 8-bit instructions from program ROM with a req/ack handshake and decodes them. It then drives one-cycle control pulses to the program counter (increment or load), the register A/B/output-port load enables, and the ALU input select. It owns the instruction register and the carry flag, and sits between the program ROM and the PC/register/ALU datapath.

## Interface
Parameters:
- IW, 8, instruction width: opcode [7:4], immediate [3:0].
- AW, 4, program-counter / ROM address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- run  in  1  level; enables execution, sampled at instruction boundaries.
- rom_req  out  1  fetch request; held high in FETCH until acknowledged.
- rom_ack  in  1  ROM data valid this cycle; ignored outside FETCH.
- rom_data  in  IW  instruction word, valid when rom_ack=1.
- alu_carry  in  1  carry out of the 4-bit adder for the current EXEC cycle.
- pc_inc  out  1  PC increment-enable pulse.
- pc_load  out  1  PC load pulse (pc_load and pc_inc are mutually exclusive).
- pc_data  out  AW  jump target, equal to ir[3:0].
- sel  out  2  ALU operand-A select: 00=A, 01=B, 10=IN port, 11=zero.
- imm  out  4  ALU immediate, equal to ir[3:0].
- ld_a, ld_b, ld_out  out  1 each  register / output-port load-enable pulses.
- c_flag  out  1  carry flag.
- busy  out  1  high in FETCH and EXEC.
- illegal  out  1  one-cycle pulse when an undefined opcode executes.

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE -> FETCH when run=1. Otherwise remain in IDLE with all pulses low.
- FETCH: rom_req=1. When rom_ack=1: ir <= rom_data, then go to EXEC. Any number of wait cycles is allowed.
- EXEC: lasts exactly 1 cycle. The decoded pulses are driven combinationally from ir.
  - At the end of EXEC, go to FETCH if run=1, otherwise to IDLE.
  - c_flag update: set to alu_carry for ADD opcodes; cleared to 0 for every other executed opcode, including jumps and illegal opcodes.
- Decode (opcode -> sel, loads, PC action):
  - 0000 ADD A,Im: sel=00, ld_a, pc_inc.
  - 0001 MOV A,B: sel=01, ld_a, pc_inc.
  - 0010 IN A: sel=10, ld_a, pc_inc.
  - 0011 MOV A,Im: sel=11, ld_a, pc_inc.
  - 0100 MOV B,A: sel=00, ld_b, pc_inc.
  - 0101 ADD B,Im: sel=01, ld_b, pc_inc.
  - 0110 IN B: sel=10, ld_b, pc_inc.
  - 0111 MOV B,Im: sel=11, ld_b, pc_inc.
  - 1001 OUT B: sel=01, ld_out, pc_inc.
  - 1011 OUT Im: sel=11, ld_out, pc_inc.
  - 1110 JNC Im: if c_flag=0 then pc_load, else pc_inc. The test uses the c_flag value from before this instruction's update.
  - 1111 JMP Im: sel=11, pc_load.
  - 1000, 1010, 1100, 1101: no-op. Assert pc_inc and illegal only.
- PC wrap-around (1111 -> 0000) belongs to the PC block; the sequencer takes no special action.
- run is sampled only in IDLE and at the end of EXEC. Dropping run during FETCH lets the current instruction complete, then the block goes to IDLE.

## Timing
- Reset values: state=IDLE, ir=0, c_flag=0. All outputs are 0, including rom_req, the pulses, sel=00, imm=0, pc_data=0, busy and illegal.
- Asynchronous reset in FETCH or EXEC aborts immediately. No pulse is emitted after rst rises, and an in-flight rom_ack is discarded.
- Zero-wait ROM (rom_ack in the first FETCH cycle): 2 cycles per instruction. Each wait cycle adds 1.
- Pulses are high only in the EXEC cycle, so each is exactly 1 cycle wide. The datapath captures them on the edge that ends EXEC.
- rom_req deasserts in the cycle after the ack (registered state).
- run 0 -> 1 in IDLE: FETCH begins the next cycle.

## Structure
- Shared package cpu_pkg:
  - opcode localparams (OP_ADD_A … OP_JMP);
  - sel encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO);
  - state typedef {IDLE, FETCH, EXEC}.
- Sub-module cpu_decode: purely combinational, ir[7:4] + c_flag -> sel, ld_a, ld_b, ld_out, pc_inc, pc_load, illegal, is_add. The sequencer gates its outputs with state==EXEC.
- The FSM, ir and c_flag live in cpu_sequencer.

## Test plan
- Reset mid-FETCH: assert rst while rom_req=1 -> rom_req=0 immediately. After release with run=0, the block stays in IDLE and all outputs are 0.
- Zero-wait program: 0x33 (MOV A,3) then 0x01 (ADD A,1) -> ld_a pulses every 2nd cycle, sel=11 then 00, imm=3 then 1, pc_inc each EXEC.
- Carry/JNC: ADD A,Im with alu_carry=1, then 0xE5 -> pc_inc (no jump), c_flag cleared. The next 0xE5 gives pc_load with pc_data=5.
- Wait states: rom_ack delayed 3 cycles -> rom_req stays high 4 cycles, ir is captured on the ack, and exactly one EXEC follows.
- run drop: deassert run during FETCH -> the fetched instruction executes once, then IDLE with busy=0. Reasserting run resumes with FETCH.
- Illegal 0x8x: illegal and pc_inc pulse for 1 cycle, no ld_* pulse, c_flag=0.
